top: RTL and testbench



---
 rtl/top.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_top.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Self-contained compute block: rotating fixed tasks (triple multiply, 4-bit pattern count,
// minimum pair distance) running against an internal 256x8 data memory and 16x8 scratch file.

module dmem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] guts [0:(1<<AW)-1];

    assign rdata = guts[raddr];

    // Single synchronous write port; contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            guts[waddr] <= wdata;
        end
    end
endmodule

module rfile #(
    parameter int DW = 8,
    parameter int RN = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] core [0:RN-1];

    assign rdata = core[raddr];

    // Scratch write port; every entry is written by a task before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            core[waddr] <= wdata;
        end
    end
endmodule

module top #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int RN = 16
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam int RW = $clog2(RN);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_MA, S_MB, S_MUL, S_MNEXT,
        S_PSET, S_SCAN, S_LDJ, S_CMP, S_WR0, S_WR1, S_FIN, S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      task_sel = 2'd0;

    logic [7:0]      cnt;
    logic [15:0]     acc;
    logic [15:0]     mcand;
    logic [7:0]      mplier;
    logic [2:0]      bitc;
    logic            pass;
    logic [3:0]      pat;
    logic            pat_ok;
    logic [7:0]      count;
    logic [7:0]      aj;
    logic [4:0]      j;
    logic [4:0]      k;
    logic [7:0]      minv;

    logic            dm_we;
    logic [AW-1:0]   dm_waddr;
    logic [DW-1:0]   dm_wdata;
    logic [AW-1:0]   dm_raddr;
    logic [DW-1:0]   dm_rdata;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [RW-1:0]   rf_raddr;
    logic [DW-1:0]   rf_rdata;

    logic signed [8:0] diff_s;
    logic [8:0]        dist_s;

    dmem #(.DW(DW), .AW(AW)) dm1 (
        .clk   (clk),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .raddr (dm_raddr),
        .rdata (dm_rdata)
    );

    rfile #(.DW(DW), .RN(RN), .RW(RW)) rf1 (
        .clk   (clk),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    function automatic logic win_match(input logic [7:0] b, input logic [3:0] p);
        logic m;
        m = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m = m | (b[i +: 4] == p);
        end
        return m;
    endfunction

    // Absolute distance between the held j-operand and the byte currently read.
    always_comb begin
        diff_s = $signed({1'b0, dm_rdata}) - $signed({1'b0, aj});
        if (diff_s[8]) begin
            dist_s = 9'd0 - $unsigned(diff_s);
        end else begin
            dist_s = $unsigned(diff_s);
        end
    end

    // Memory port steering derived from the current state.
    always_comb begin
        dm_we    = 1'b0;
        dm_waddr = 8'd0;
        dm_wdata = 8'd0;
        dm_raddr = 8'd0;
        rf_we    = 1'b0;
        rf_waddr = {RW{1'b0}};
        rf_wdata = 8'd0;
        rf_raddr = {RW{1'b0}};
        case (state)
            S_LOAD: begin
                dm_raddr = 8'd1 + cnt;
                rf_we    = 1'b1;
                rf_waddr = cnt[RW-1:0];
                rf_wdata = dm_rdata;
            end
            S_MA:    rf_raddr = RW'(0);
            S_MB:    rf_raddr = RW'(1);
            S_MNEXT: rf_raddr = RW'(2);
            S_PSET:  dm_raddr = 8'd6;
            S_SCAN:  dm_raddr = 8'd32 + cnt;
            S_LDJ:   dm_raddr = 8'd128 + {3'd0, j};
            S_CMP:   dm_raddr = 8'd128 + {3'd0, k};
            S_WR0: begin
                case (task_sel)
                    2'd0: begin
                        dm_we    = 1'b1;
                        dm_waddr = 8'd4;
                        dm_wdata = acc[15:8];
                    end
                    2'd1: begin
                        dm_we    = 1'b1;
                        dm_waddr = 8'd7;
                        dm_wdata = count;
                    end
                    2'd2: begin
                        dm_we    = 1'b1;
                        dm_waddr = 8'd127;
                        dm_wdata = minv;
                    end
                    default: dm_we = 1'b0;
                endcase
            end
            S_WR1: begin
                dm_we    = 1'b1;
                dm_waddr = 8'd5;
                dm_wdata = acc[7:0];
            end
            default: dm_we = 1'b0;
        endcase
    end

    // Rotation pointer survives reset; it steps only as a task completes.
    always_ff @(posedge clk) begin
        if (state == S_FIN) begin
            task_sel <= (task_sel == 2'd2) ? 2'd0 : task_sel + 2'd1;
        end
    end

    // Task sequencer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            cnt    <= 8'd0;
            acc    <= 16'd0;
            mcand  <= 16'd0;
            mplier <= 8'd0;
            bitc   <= 3'd0;
            pass   <= 1'b0;
            pat    <= 4'd0;
            pat_ok <= 1'b0;
            count  <= 8'd0;
            aj     <= 8'd0;
            j      <= 5'd0;
            k      <= 5'd0;
            minv   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt   <= 8'd0;
                    pass  <= 1'b0;
                    acc   <= 16'd0;
                    count <= 8'd0;
                    j     <= 5'd0;
                    minv  <= 8'hFF;
                    case (task_sel)
                        2'd1:    state <= S_PSET;
                        2'd2:    state <= S_LDJ;
                        default: state <= S_LOAD;
                    endcase
                end
                S_LOAD: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd2) begin
                        state <= S_MA;
                    end
                end
                S_MA: begin
                    mcand <= {8'd0, rf_rdata};
                    acc   <= 16'd0;
                    state <= S_MB;
                end
                S_MB: begin
                    mplier <= rf_rdata;
                    bitc   <= 3'd0;
                    state  <= S_MUL;
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    bitc   <= bitc + 3'd1;
                    if (bitc == 3'd7) begin
                        state <= S_MNEXT;
                    end
                end
                // Second pass multiplies the 16-bit partial product by the third operand.
                S_MNEXT: begin
                    if (!pass) begin
                        mcand  <= acc;
                        acc    <= 16'd0;
                        mplier <= rf_rdata;
                        bitc   <= 3'd0;
                        pass   <= 1'b1;
                        state  <= S_MUL;
                    end else begin
                        state <= S_WR0;
                    end
                end
                S_PSET: begin
                    pat    <= dm_rdata[3:0];
                    pat_ok <= (dm_rdata[7:4] == 4'd0);
                    cnt    <= 8'd0;
                    count  <= 8'd0;
                    state  <= S_SCAN;
                end
                S_SCAN: begin
                    if (pat_ok && win_match(dm_rdata, pat)) begin
                        count <= count + 8'd1;
                    end
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd63) begin
                        state <= S_WR0;
                    end
                end
                S_LDJ: begin
                    aj    <= dm_rdata;
                    k     <= j + 5'd1;
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (dist_s < {1'b0, minv}) begin
                        minv <= dist_s[7:0];
                    end
                    if (k == 5'd19) begin
                        if (j == 5'd18) begin
                            state <= S_WR0;
                        end else begin
                            j     <= j + 5'd1;
                            state <= S_LDJ;
                        end
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                S_WR0:   state <= (task_sel == 2'd0) ? S_WR1 : S_FIN;
                S_WR1:   state <= S_FIN;
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_top.sv
// Directed-plus-random bench for top: preloads memories hierarchically, releases reset and
// compares results against a behavioural model of the three tasks.

module tb_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;

    int vectors = 0;
    int miscompares = 0;
    int ts = 0;
    logic [7:0] snap [0:255];

    top dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_mul();
        int p;
        p = int'(snap[1]) * int'(snap[2]) * int'(snap[3]);
        return p % 65536;
    endfunction

    function automatic int ref_cnt();
        int n, pat, b, hit;
        n = 0;
        pat = int'(snap[6]);
        if (pat > 15) return 0;
        for (int a = 32; a <= 95; a++) begin
            b = int'(snap[a]);
            hit = 0;
            for (int s = 0; s <= 4; s++) begin
                if (((b >> s) % 16) == pat) hit = 1;
            end
            n += hit;
        end
        return n;
    endfunction

    function automatic int ref_min();
        int m, d;
        m = 255;
        for (int x = 128; x <= 146; x++) begin
            for (int y = x + 1; y <= 147; y++) begin
                d = int'(snap[y]) - int'(snap[x]);
                if (d < 0) d = -d;
                if (d < m) m = d;
            end
        end
        return m;
    endfunction

    function automatic bit is_result(input int a);
        case (ts)
            0:       return (a == 4) || (a == 5);
            1:       return (a == 7);
            default: return (a == 127);
        endcase
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("done_in_reset", done, 0);
        for (int i = 0; i < 16; i++) dut.rf1.core[i] = 8'($urandom);
    endtask

    task automatic run_and_check();
        int lat, cap, nbad, p;
        for (int a = 0; a < 256; a++) snap[a] = dut.dm1.guts[a];
        cap = (ts == 0) ? 40 : ((ts == 1) ? 300 : 800);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_within_cap", (lat <= cap) ? 1 : 0, 1);
        case (ts)
            0: begin
                p = ref_mul();
                check("mul_hi", dut.dm1.guts[4], p / 256);
                check("mul_lo", dut.dm1.guts[5], p % 256);
            end
            1: check("pat_count", dut.dm1.guts[7], ref_cnt());
            default: check("min_dist", dut.dm1.guts[127], ref_min());
        endcase
        nbad = 0;
        for (int a = 0; a < 256; a++) begin
            if (!is_result(a) && dut.dm1.guts[a] !== snap[a]) nbad++;
        end
        check("no_stray_writes", nbad, 0);
        ts = (ts + 1) % 3;
        check("task_sel_next", dut.task_sel, ts);
        repeat (3) @(negedge clk);
        check("done_held", done, 1);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) dut.dm1.guts[a] = 8'($urandom);
        for (int i = 0; i < 16; i++) dut.rf1.core[i] = 8'($urandom);
        dut.dm1.guts[1] = 8'd5;
        dut.dm1.guts[2] = 8'd15;
        dut.dm1.guts[3] = 8'd2;
        repeat (2) @(negedge clk);
        check("reset_done", done, 0);
        check("powerup_task_sel", dut.task_sel, 0);
        run_and_check();
        check("t0_product_150", {dut.dm1.guts[4], dut.dm1.guts[5]}, 16'd150);

        hold_reset();
        dut.dm1.guts[6] = 8'h0D;
        for (int a = 32; a <= 95; a++) dut.dm1.guts[a] = 8'($urandom);
        run_and_check();

        hold_reset();
        for (int a = 128; a <= 147; a++) dut.dm1.guts[a] = 8'($urandom);
        run_and_check();

        hold_reset();
        dut.dm1.guts[1] = 8'd255;
        dut.dm1.guts[2] = 8'd255;
        dut.dm1.guts[3] = 8'd255;
        run_and_check();
        check("t0_product_max", {dut.dm1.guts[4], dut.dm1.guts[5]}, 16'h02FF);

        hold_reset();
        dut.dm1.guts[6] = 8'h00;
        for (int a = 32; a <= 95; a++) dut.dm1.guts[a] = 8'h00;
        run_and_check();
        check("t1_all_zero_64", dut.dm1.guts[7], 64);

        hold_reset();
        for (int a = 128; a <= 147; a++) dut.dm1.guts[a] = 8'(a * 12);
        dut.dm1.guts[140] = dut.dm1.guts[131];
        run_and_check();
        check("t2_duplicate_0", dut.dm1.guts[127], 0);

        // Abort a multiply part-way; the rotation pointer must not move.
        hold_reset();
        for (int a = 1; a <= 3; a++) dut.dm1.guts[a] = 8'($urandom);
        dut.dm1.guts[4] = 8'hA5;
        dut.dm1.guts[5] = 8'h5A;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_done_low", done, 0);
        repeat (3) @(negedge clk);
        check("abort_no_write", {dut.dm1.guts[4], dut.dm1.guts[5]}, 16'hA55A);
        check("abort_task_sel", dut.task_sel, ts);
        run_and_check();

        hold_reset();
        dut.dm1.guts[6] = 8'h3D;
        for (int a = 32; a <= 95; a++) dut.dm1.guts[a] = 8'($urandom);
        dut.dm1.guts[40] = 8'h0D;
        run_and_check();
        check("t1_bad_pat_0", dut.dm1.guts[7], 0);

        for (int r = 0; r < 6; r++) begin
            hold_reset();
            for (int a = 0; a < 256; a++) dut.dm1.guts[a] = 8'($urandom);
            if (r % 2 == 0) dut.dm1.guts[6] = 8'($urandom_range(15, 0));
            run_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
